// File: rtl/pbch_scramble_qpsk_tx.sv
// pbch_scramble_qpsk_tx
// Transmit-side PBCH scrambler and QPSK mapper. One SSB worth of coded bits
// (Mpn of them) is XORed with the cell-specific Gold sequence, offset by the
// SSB index, and consecutive bit pairs are mapped to signed I/Q components.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset
//   start      : one-cycle pulse beginning an SSB (only honoured when idle)
//   ncellid    : cell ID, used as the Gold-sequence c_init (sampled on start)
//   issb       : SSB index LSBs selecting the sequence offset (sampled on start)
//   in_bit     : coded PBCH bit
//   in_valid   : in_bit is valid this cycle
//   in_ready   : block accepts a bit this cycle
//   mod_i      : signed I component of the current symbol
//   mod_q      : signed Q component of the current symbol
//   out_valid  : one-cycle pulse, mod_i/mod_q carry a new symbol
//   done       : one-cycle pulse alongside the last symbol of the SSB

module pbch_scramble_qpsk_tx #(
    parameter int WORD_LENGTH = 8,
    parameter int AMP         = 45,
    parameter int Mpn         = 864,
    parameter int NC          = 1600
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [9:0]                    ncellid,
    input  logic [1:0]                    issb,
    input  logic                          in_bit,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic signed [WORD_LENGTH-1:0] mod_i,
    output logic signed [WORD_LENGTH-1:0] mod_q,
    output logic                          out_valid,
    output logic                          done
);

    localparam logic [12:0] NC_W     = 13'(NC);
    localparam logic [12:0] MPN_W    = 13'(Mpn);
    localparam logic [9:0]  LAST_BIT = 10'(Mpn - 1);
    localparam logic signed [WORD_LENGTH-1:0] POS_AMP = WORD_LENGTH'(AMP);
    localparam logic signed [WORD_LENGTH-1:0] NEG_AMP = WORD_LENGTH'(-AMP);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    // One step of the x1 m-sequence: x1(n+31) = x1(n+3) ^ x1(n).
    function automatic logic [30:0] x1_step(input logic [30:0] x);
        return {x[3] ^ x[0], x[30:1]};
    endfunction

    // One step of the x2 m-sequence: x2(n+31) = x2(n+3)^x2(n+2)^x2(n+1)^x2(n).
    function automatic logic [30:0] x2_step(input logic [30:0] x);
        return {x[3] ^ x[2] ^ x[1] ^ x[0], x[30:1]};
    endfunction

    state_t                          state_r;
    state_t                          state_next_s;
    logic [30:0]                     x1_r;
    logic [30:0]                     x2_r;
    logic [12:0]                     warm_cnt_r;
    logic [9:0]                      bit_cnt_r;
    logic                            s_i_r;
    logic [9:0]                      ncellid_r;
    logic [1:0]                      issb_r;
    logic                            in_ready_r;
    logic signed [WORD_LENGTH-1:0]   mod_i_r;
    logic signed [WORD_LENGTH-1:0]   mod_q_r;
    logic                            out_valid_r;
    logic                            done_r;

    logic                            c_s;
    logic                            s_s;
    logic                            accept_s;
    logic                            last_bit_s;
    logic                            in_ready_next_s;
    logic                            sym_fire_s;
    logic                            done_next_s;

    assign c_s        = x1_r[0] ^ x2_r[0];
    assign s_s        = in_bit ^ c_s;
    assign accept_s   = (state_r == ST_RUN) & in_valid & in_ready_r;
    assign last_bit_s = (bit_cnt_r == LAST_BIT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_next_s = ST_WARMUP;
            end
            ST_WARMUP: begin
                // The step taken in the cycle where the count is 1 is the last one.
                if (warm_cnt_r <= 13'd1) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_WARMUP;
                end
            end
            ST_RUN: begin
                if (accept_s && last_bit_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: values the output registers take at the next edge.
    always_comb begin
        in_ready_next_s = 1'b0;
        sym_fire_s      = 1'b0;
        done_next_s     = 1'b0;
        // Ready is registered, so it follows the state we are moving into;
        // leaving RUN on the final bit drops it together with the state change.
        if (state_next_s == ST_RUN) begin
            in_ready_next_s = 1'b1;
        end else begin
            in_ready_next_s = 1'b0;
        end
        // Odd-index bits complete a symbol.
        if (accept_s && bit_cnt_r[0]) begin
            sym_fire_s  = 1'b1;
            done_next_s = last_bit_s;
        end else begin
            sym_fire_s  = 1'b0;
            done_next_s = 1'b0;
        end
    end

    // Datapath: Gold generator, counters, symbol registers and output flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            x1_r        <= 31'd0;
            x2_r        <= 31'd0;
            warm_cnt_r  <= 13'd0;
            bit_cnt_r   <= 10'd0;
            s_i_r       <= 1'b0;
            ncellid_r   <= 10'd0;
            issb_r      <= 2'd0;
            in_ready_r  <= 1'b0;
            mod_i_r     <= '0;
            mod_q_r     <= '0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_next_s;
            out_valid_r <= sym_fire_s;
            done_r      <= done_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        ncellid_r <= ncellid;
                        issb_r    <= issb;
                    end
                end
                ST_LOAD: begin
                    x1_r       <= 31'h1;
                    x2_r       <= {21'd0, ncellid_r};
                    // Warm-up skips NC steps plus one SSB stride per index.
                    warm_cnt_r <= NC_W + (MPN_W * {11'd0, issb_r});
                    bit_cnt_r  <= 10'd0;
                    s_i_r      <= 1'b0;
                end
                ST_WARMUP: begin
                    x1_r       <= x1_step(x1_r);
                    x2_r       <= x2_step(x2_r);
                    warm_cnt_r <= warm_cnt_r - 13'd1;
                end
                ST_RUN: begin
                    if (accept_s) begin
                        x1_r      <= x1_step(x1_r);
                        x2_r      <= x2_step(x2_r);
                        bit_cnt_r <= bit_cnt_r + 10'd1;
                        if (!bit_cnt_r[0]) begin
                            s_i_r <= s_s;
                        end else begin
                            mod_i_r <= s_i_r ? NEG_AMP : POS_AMP;
                            mod_q_r <= s_s   ? NEG_AMP : POS_AMP;
                        end
                    end
                end
                default: begin
                    x1_r <= x1_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign mod_i     = mod_i_r;
    assign mod_q     = mod_q_r;
    assign out_valid = out_valid_r;
    assign done      = done_r;

endmodule

// File: tb/tb_pbch_scramble_qpsk_tx.sv
// Self-checking bench for pbch_scramble_qpsk_tx. Expected symbols come from a
// Gold-sequence table built with the sequence recurrences over whole arrays,
// and every SSB is also descrambled back to its source bits.

module tb_pbch_scramble_qpsk_tx;

    localparam int MPN    = 864;
    localparam int NCW    = 1600;
    localparam int AMPV   = 45;
    localparam int GLEN   = 5100;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [9:0]        ncellid;
    logic [1:0]        issb;
    logic              in_bit;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] mod_i;
    logic signed [7:0] mod_q;
    logic              out_valid;
    logic              done;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    bit gold_c [GLEN];
    bit bits   [MPN];
    int got_i  [MPN/2];
    int got_q  [MPN/2];
    int ref_i  [MPN/2];
    int ref_q  [MPN/2];

    pbch_scramble_qpsk_tx dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ncellid   (ncellid),
        .issb      (issb),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mod_i     (mod_i),
        .mod_q     (mod_q),
        .out_valid (out_valid),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_value(input string tag, input int got, input int exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // c(n) = x1(n) ^ x2(n) from the recurrences, x1 seeded with 1, x2 with c_init.
    task automatic gen_gold(input logic [9:0] cinit);
        bit x1 [GLEN + 31];
        bit x2 [GLEN + 31];
        for (int n = 0; n < 31; n++) begin
            x1[n] = (n == 0);
            x2[n] = (n < 10) ? cinit[n] : 1'b0;
        end
        for (int n = 0; n < GLEN; n++) begin
            x1[n + 31] = x1[n + 3] ^ x1[n];
            x2[n + 31] = x2[n + 3] ^ x2[n + 2] ^ x2[n + 1] ^ x2[n];
            gold_c[n]  = x1[n] ^ x2[n];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one full SSB from start to done with optional input gaps and stray starts.
    task automatic run_ssb(input logic [9:0] cid, input logic [1:0] v,
                           input int gap_pct, input bit stray);
        int off;
        int t0;
        int idx;
        int k;
        int ncyc;
        int errs;
        bit ready_seen;
        bit fin;
        bit rec;
        gen_gold(cid);
        off        = NCW + int'(v) * MPN;
        idx        = 0;
        k          = 0;
        ncyc       = 0;
        ready_seen = 1'b0;
        fin        = 1'b0;
        ncellid    = cid;
        issb       = v;
        start      = 1'b1;
        t0         = cyc;
        tick();
        start   = 1'b0;
        ncellid = 10'($urandom);
        issb    = 2'($urandom);
        while (!fin && ncyc < 9000) begin
            if (in_ready && !ready_seen) begin
                ready_seen = 1'b1;
                chk_value("warmup_len", cyc - t0, 2 + NCW + int'(v) * MPN);
            end
            if (out_valid) begin
                got_i[k] = int'(mod_i);
                got_q[k] = int'(mod_q);
                chk_value("sym_i", int'(mod_i),
                          (bits[2*k] ^ gold_c[off + 2*k]) ? -AMPV : AMPV);
                chk_value("sym_q", int'(mod_q),
                          (bits[2*k+1] ^ gold_c[off + 2*k+1]) ? -AMPV : AMPV);
                chk_value("done", int'(done), (k == MPN/2 - 1) ? 1 : 0);
                k++;
                if (k == MPN/2) begin
                    fin = 1'b1;
                    chk_value("ready_after_done", int'(in_ready), 0);
                end
            end else begin
                if (done) chk_value("done_no_valid", int'(done), 0);
                if (k > 0) begin
                    chk_value("hold_i", int'(mod_i), got_i[k-1]);
                    chk_value("hold_q", int'(mod_q), got_q[k-1]);
                end
            end
            if (!fin) begin
                if (stray && ($urandom_range(40, 0) == 0)) begin
                    start   = 1'b1;
                    ncellid = 10'($urandom);
                    issb    = 2'($urandom);
                end else begin
                    start = 1'b0;
                end
                if (in_ready && idx < MPN && ($urandom_range(99, 0) >= gap_pct)) begin
                    in_valid = 1'b1;
                    in_bit   = bits[idx];
                    idx++;
                end else begin
                    in_valid = 1'b0;
                    in_bit   = 1'($urandom);
                end
                tick();
                ncyc++;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (!fin) begin
            chk_value("timeout_symbols", k, MPN/2);
        end else begin
            errs = 0;
            for (int i = 0; i < MPN; i++) begin
                rec = ((i % 2 == 0) ? (got_i[i/2] < 0) : (got_q[i/2] < 0)) ^ gold_c[off + i];
                if (rec != bits[i]) errs++;
            end
            chk_value("loopback_errs", errs, 0);
        end
    endtask

    task automatic rand_bits();
        for (int i = 0; i < MPN; i++) bits[i] = 1'($urandom);
    endtask

    initial begin
        int errs;
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        ncellid  = 10'd0;
        issb     = 2'd0;
        in_bit   = 1'b0;
        in_valid = 1'b0;
        repeat (3) tick();
        chk_value("reset_outs", int'({in_ready, out_valid, done, mod_i, mod_q}), 0);
        rst = 1'b0;
        tick();

        // All-zero input: symbols are the bare Gold sequence from c(1600).
        for (int i = 0; i < MPN; i++) bits[i] = 1'b0;
        run_ssb(10'd0, 2'd0, 0, 1'b0);

        // Force the four (s_i, s_q) combinations on the first four symbols.
        gen_gold(10'd433);
        rand_bits();
        begin
            bit pat [8];
            pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
            for (int i = 0; i < 8; i++) bits[i] = pat[i] ^ gold_c[NCW + i];
        end
        run_ssb(10'd433, 2'd0, 0, 1'b0);
        chk_value("pair00", (got_i[0] << 8) + got_q[0], ( AMPV << 8) + AMPV);
        chk_value("pair10", (got_i[1] << 8) + got_q[1], (-AMPV << 8) + AMPV);
        chk_value("pair01", (got_i[2] << 8) + got_q[2], ( AMPV << 8) - AMPV);
        chk_value("pair11", (got_i[3] << 8) + got_q[3], (-AMPV << 8) - AMPV);

        // Longest warm-up.
        rand_bits();
        run_ssb(10'd433, 2'd3, 0, 1'b0);

        // Same bits with and without input gaps must give the same symbols.
        rand_bits();
        run_ssb(10'd1007, 2'd2, 0, 1'b0);
        for (int i = 0; i < MPN/2; i++) begin
            ref_i[i] = got_i[i];
            ref_q[i] = got_q[i];
        end
        run_ssb(10'd1007, 2'd2, 30, 1'b0);
        errs = 0;
        for (int i = 0; i < MPN/2; i++) begin
            if (got_i[i] != ref_i[i] || got_q[i] != ref_q[i]) errs++;
        end
        chk_value("stall_seq_diffs", errs, 0);

        // Stray start pulses during warm-up and run.
        rand_bits();
        run_ssb(10'($urandom), 2'd1, 10, 1'b1);

        // Reset in the middle of a run, then a clean restart.
        ncellid = 10'd433;
        issb    = 2'd0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        n     = 0;
        while (!in_ready && n < 2000) begin
            tick();
            n++;
        end
        chk_value("mid_ready", int'(in_ready), 1);
        for (int i = 0; i < 101; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        chk_value("mid_reset_outs", int'({in_ready, out_valid, done, mod_i, mod_q}), 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk_value("post_reset_outs", int'({in_ready, out_valid, done, mod_i, mod_q}), 0);
        rand_bits();
        run_ssb(10'd777, 2'd1, 20, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
